// File: rtl/fft_sdf_stage_ctrl.sv
// Control sequencer for one radix-2 DIF single-delay-feedback FFT stage.
// Drives delay-line shift, butterfly select, zero flush and output tagging.
module fft_sdf_stage_ctrl #(
    parameter int N     = 32,
    parameter int STAGE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic                   shift_en,
    output logic                   zero_in,
    output logic                   sel_bf,
    output logic                   valid_o,
    output logic                   diff_o,
    output logic [$clog2(N)-2:0]   tw_addr,
    output logic                   frame_done,
    output logic                   busy
);

    localparam int LOGN = $clog2(N);
    localparam int D    = N >> (STAGE + 1);
    localparam int LD   = $clog2(D);

    localparam logic [LOGN-1:0] CNT_D    = LOGN'(D);
    localparam logic [LOGN-1:0] CNT_DM1  = LOGN'(D - 1);
    localparam logic [LOGN-1:0] CNT_LAST = LOGN'(N - 1);
    localparam logic [LOGN-2:0] TW_MASK  = (LOGN-1)'(D - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    logic [1:0]      state;
    logic [LOGN-1:0] in_cnt;
    logic [LOGN-1:0] o_cnt;
    logic [LOGN-1:0] fl_cnt;
    logic            primed;

    logic acc;
    logic adv;
    logic in_flush;
    logic out_fire;
    logic to_flush;
    logic to_idle;

    // Twiddle index for an output: W_N^((k mod D) << STAGE) on differences, 0 on sums.
    function automatic logic [LOGN-2:0] tw_index(input logic [LOGN-1:0] k);
        if (k[LD])
            return (k[LOGN-2:0] & TW_MASK) << STAGE;
        else
            return '0;
    endfunction

    always_comb begin
        in_flush = (state == FLUSH);
        ready_o  = !in_flush;
        acc      = valid_i & ready_o;
        adv      = acc | in_flush;
        shift_en = adv;
        zero_in  = in_flush;
        sel_bf   = in_cnt[LD];
        busy     = (state != IDLE);
        out_fire = adv & (primed | (in_cnt == CNT_D));
        // A frame boundary with no follow-on sample starts the zero flush.
        to_flush = (state == RUN) && (in_cnt == '0) && primed && !valid_i;
        to_idle  = in_flush && (fl_cnt == CNT_DM1);
    end

    // Stage p0 -> p1: control state and registered output tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_cnt     <= '0;
            o_cnt      <= '0;
            fl_cnt     <= '0;
            primed     <= 1'b0;
            valid_o    <= 1'b0;
            diff_o     <= 1'b0;
            tw_addr    <= '0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (acc)      state <= RUN;
                RUN:     if (to_flush) state <= FLUSH;
                FLUSH:   if (to_idle)  state <= IDLE;
                default:               state <= IDLE;
            endcase

            if (to_flush)
                fl_cnt <= '0;
            else if (in_flush)
                fl_cnt <= fl_cnt + 1'b1;

            if (to_idle)
                in_cnt <= '0;
            else if (adv)
                in_cnt <= in_cnt + 1'b1;

            if (to_idle)
                primed <= 1'b0;
            else if (adv && (in_cnt == CNT_DM1))
                primed <= 1'b1;

            if (to_idle)
                o_cnt <= '0;
            else if (out_fire)
                o_cnt <= o_cnt + 1'b1;

            valid_o    <= out_fire;
            frame_done <= out_fire && (o_cnt == CNT_LAST);
            if (out_fire) begin
                diff_o  <= o_cnt[LD];
                tw_addr <= tw_index(o_cnt);
            end
        end
    end

endmodule

// File: tb/tb_fft_sdf_stage_ctrl.sv
// Directed bench for fft_sdf_stage_ctrl: cycle tables for STAGE=1 and STAGE=4
// single frames, plus hand sequences for back-to-back, gap, flush and reset cases.
module tb_fft_sdf_stage_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic v1  = 1'b0;
    logic v4  = 1'b0;

    logic r1, se1, z1, sb1, vo1, d1, fd1, b1;
    logic r4, se4, z4, sb4, vo4, d4, fd4, b4;
    logic [3:0] tw1, tw4;

    fft_sdf_stage_ctrl #(.N(32), .STAGE(1)) dut1 (
        .clk(clk), .rst(rst), .valid_i(v1), .ready_o(r1), .shift_en(se1),
        .zero_in(z1), .sel_bf(sb1), .valid_o(vo1), .diff_o(d1), .tw_addr(tw1),
        .frame_done(fd1), .busy(b1)
    );

    fft_sdf_stage_ctrl #(.N(32), .STAGE(4)) dut4 (
        .clk(clk), .rst(rst), .valid_i(v4), .ready_o(r4), .shift_en(se4),
        .zero_in(z4), .sel_bf(sb4), .valid_o(vo4), .diff_o(d4), .tw_addr(tw4),
        .frame_done(fd4), .busy(b4)
    );

    always #5 clk = ~clk;

    int tsel = 1;
    logic m_rdy, m_se, m_z, m_sb, m_vo, m_d, m_fd, m_b;
    logic [3:0] m_tw;
    always_comb begin
        if (tsel == 4) begin
            m_rdy = r4; m_se = se4; m_z = z4; m_sb = sb4;
            m_vo = vo4; m_d = d4; m_fd = fd4; m_b = b4; m_tw = tw4;
        end else begin
            m_rdy = r1; m_se = se1; m_z = z1; m_sb = sb1;
            m_vo = vo1; m_d = d1; m_fd = fd1; m_b = b1; m_tw = tw1;
        end
    end

    typedef struct {
        logic       vin, shift, sel, zero, rdy, busy, vo, diff, fd;
        logic [3:0] tw;
    } vec_t;

    vec_t tbl1[$];
    vec_t tbl4[$];

    int n_chk  = 0;
    int n_fail = 0;

    int n_shift, n_zero, n_rdy_low, n_acc;
    logic c_shift, c_rdy, last_vo;
    logic [5:0] outq[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic vin, input logic shift, input logic sel,
                                input logic zero, input logic rdy, input logic bsy,
                                input logic vo, input logic diff, input logic [3:0] tw,
                                input logic fd);
        vec_t e;
        e.vin = vin; e.shift = shift; e.sel = sel; e.zero = zero; e.rdy = rdy;
        e.busy = bsy; e.vo = vo; e.diff = diff; e.tw = tw; e.fd = fd;
        return e;
    endfunction

    // Expected {frame_done, diff, tw} of the k-th output of a STAGE=1 frame (D=8).
    function automatic logic [5:0] exp_out(input int k);
        int kk;
        logic dd;
        logic [3:0] tw;
        kk = k % 32;
        dd = ((kk / 8) % 2) == 1;
        tw = dd ? 4'((kk % 8) * 2) : 4'd0;
        return {kk == 31, dd, tw};
    endfunction

    task automatic clr_acc();
        n_shift = 0; n_zero = 0; n_rdy_low = 0; n_acc = 0;
        outq.delete();
    endtask

    task automatic cyc(input logic v);
        v1 = v;
        #1;
        c_shift = se1;
        c_rdy   = r1;
        if (se1) n_shift++;
        if (z1) n_zero++;
        if (!r1) n_rdy_low++;
        if (v && r1) n_acc++;
        @(posedge clk);
        #1;
        if (vo1) outq.push_back({fd1, d1, tw1});
        last_vo = vo1;
    endtask

    task automatic check_outs(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            if (i < outq.size())
                chk($sformatf("%s out%0d", tag, i), int'(outq[i]), int'(exp_out(i)));
            else
                chk($sformatf("%s out%0d missing", tag, i), -1, int'(exp_out(i)));
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; v1 = 1'b0; v4 = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_tbl(input int which, input string tag);
        vec_t t[$];
        if (which == 4) t = tbl4;
        else            t = tbl1;
        tsel = which;
        foreach (t[i]) begin
            if (which == 4) v4 = t[i].vin;
            else            v1 = t[i].vin;
            #1;
            chk($sformatf("%s[%0d] shift_en", tag, i), m_se, t[i].shift);
            if (t[i].shift)
                chk($sformatf("%s[%0d] sel_bf", tag, i), m_sb, t[i].sel);
            chk($sformatf("%s[%0d] zero_in", tag, i), m_z, t[i].zero);
            chk($sformatf("%s[%0d] ready_o", tag, i), m_rdy, t[i].rdy);
            chk($sformatf("%s[%0d] busy", tag, i), m_b, t[i].busy);
            @(posedge clk);
            #1;
            chk($sformatf("%s[%0d] valid_o", tag, i), m_vo, t[i].vo);
            chk($sformatf("%s[%0d] diff_o", tag, i), m_d, t[i].diff);
            chk($sformatf("%s[%0d] tw_addr", tag, i), m_tw, t[i].tw);
            chk($sformatf("%s[%0d] frame_done", tag, i), m_fd, t[i].fd);
        end
        v1 = 1'b0; v4 = 1'b0;
    endtask

    initial begin
        int fdc;
        logic [5:0] eo;

        // STAGE=1 single frame: 32 samples, boundary cycle, 8 flush cycles, idle.
        for (int i = 0; i < 42; i++) begin
            if (i < 32) begin
                eo = (i >= 8) ? exp_out(i - 8) : 6'd0;
                tbl1.push_back(mk(1, 1, ((i / 8) % 2) == 1, 0, 1, i != 0,
                                  i >= 8, eo[4], eo[3:0], 0));
            end else if (i == 32) begin
                tbl1.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 4'd0, 0));
            end else if (i < 41) begin
                tbl1.push_back(mk(0, 1, 0, 1, 0, 1, 1, 1, 4'((i - 33) * 2), i == 40));
            end else begin
                tbl1.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 4'd14, 0));
            end
        end
        // STAGE=4 single frame (D=1): alternating sel_bf, tw always 0, 1-cycle flush.
        for (int i = 0; i < 35; i++) begin
            if (i < 32)
                tbl4.push_back(mk(1, 1, (i % 2) == 1, 0, 1, i != 0, i >= 1,
                                  (i >= 1) && (((i - 1) % 2) == 1), 4'd0, 0));
            else if (i == 32)
                tbl4.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 4'd0, 0));
            else if (i == 33)
                tbl4.push_back(mk(0, 1, 0, 1, 0, 1, 1, 1, 4'd0, 1));
            else
                tbl4.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 4'd0, 0));
        end

        // Reset held two cycles, then released with no valid_i.
        repeat (2) @(posedge clk);
        #1;
        chk("rst valid_o", vo1, 0);
        chk("rst diff_o", d1, 0);
        chk("rst tw_addr", tw1, 0);
        chk("rst frame_done", fd1, 0);
        chk("rst busy", b1, 0);
        chk("rst ready_o", r1, 1);
        chk("rst busy s4", b4, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post-rst valid_o", vo1, 0);
        chk("post-rst diff_o", d1, 0);
        chk("post-rst tw_addr", tw1, 0);
        chk("post-rst frame_done", fd1, 0);
        chk("post-rst busy", b1, 0);
        chk("post-rst ready_o", r1, 1);

        run_tbl(1, "single");

        // Back-to-back frames: no flush between them, a single flush at the end.
        clr_acc();
        repeat (64) cyc(1);
        chk("b2b ready low during frames", n_rdy_low, 0);
        chk("b2b accepted", n_acc, 64);
        repeat (11) cyc(0);
        chk("b2b ready low total", n_rdy_low, 8);
        chk("b2b zero_in cycles", n_zero, 8);
        chk("b2b shift cycles", n_shift, 72);
        chk("b2b output count", outq.size(), 64);
        fdc = 0;
        foreach (outq[i]) if (outq[i][5]) fdc++;
        chk("b2b frame_done count", fdc, 2);
        for (int i = 0; i < 64; i++) begin
            if (i < outq.size())
                chk($sformatf("b2b out%0d", i), int'(outq[i]), int'(exp_out(i)));
        end

        // Mid-frame gap of 3 cycles after sample 12.
        clr_acc();
        repeat (12) cyc(1);
        for (int g = 0; g < 3; g++) begin
            cyc(0);
            chk($sformatf("gap%0d shift_en", g), c_shift, 0);
            chk($sformatf("gap%0d valid_o", g), last_vo, 0);
        end
        repeat (20) cyc(1);
        repeat (11) cyc(0);
        chk("gap shift cycles", n_shift, 40);
        chk("gap zero_in cycles", n_zero, 8);
        chk("gap output count", outq.size(), 32);
        check_outs("gap", 32);

        // valid_i held high through the whole flush.
        clr_acc();
        repeat (32) cyc(1);
        cyc(0);
        repeat (8) cyc(1);
        chk("vflush ready low", n_rdy_low, 8);
        chk("vflush zero_in cycles", n_zero, 8);
        chk("vflush accepted during flush", n_acc, 32);
        chk("vflush output count", outq.size(), 32);
        check_outs("vflush", 32);
        cyc(1);
        chk("vflush ready after flush", c_rdy, 1);
        chk("vflush first new sample accepted", n_acc, 33);
        repeat (7) cyc(1);
        chk("vflush no output before 9th", outq.size(), 32);
        cyc(1);
        chk("vflush output after 9th", outq.size(), 33);
        if (outq.size() > 32)
            chk("vflush new frame out0", int'(outq[32]), int'(exp_out(0)));
        do_reset(1);

        // Reset mid-frame after sample 20, with valid_i still high.
        clr_acc();
        repeat (20) cyc(1);
        chk("midrst outputs before reset", outq.size(), 12);
        v1 = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        v1 = 1'b0;
        chk("midrst valid_o", vo1, 0);
        chk("midrst busy", b1, 0);
        chk("midrst ready_o", r1, 1);
        chk("midrst diff_o", d1, 0);
        chk("midrst tw_addr", tw1, 0);
        chk("midrst frame_done", fd1, 0);
        run_tbl(1, "after-rst");

        run_tbl(4, "stage4");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
